hazard_ctrl: RTL and testbench

- Consumer side of the D-stage instruction decoder. It takes the decoder's per-instruction register-use times (Tuse) and result-ready times (Tnew) and tracks in-flight destination registers through E/M/W.
- It produces the D-stage stall and the forwarding-mux selects for the 5-stage MIPS pipeline (addu/subu/ori/lui/lw/sw/beq/j/jal/jr/nop).
- It owns its own shadow pipeline of A3/Tnew/rs/rt, so the datapath only needs the selects.

---
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- D-stage stall and forwarding-select generator for a 5-stage
// MIPS pipeline (addu/subu/ori/lui/lw/sw/beq/j/jal/jr/nop).
//
// Keeps a shadow pipeline of destination register / Tnew / source fields for
// the instructions in E, M and W. From that and the decoder's Tuse/Tnew for
// the instruction in D it derives the stall and every forwarding-mux select.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   D_rs, D_rt                  source register fields of the D instruction
//   D_A3, D_RegWrite            destination of the D instruction and its write enable
//   Tuse_rs0/1                  rs consumed in D / E
//   Tuse_rt0/1/2                rt consumed in D / E / M
//   D_Tnew                      cycles after entering E until the result exists
//   stall                       freeze PC and F/D, bubble into E
//   fwd_D_rs, fwd_D_rt          0=GRF 1=E 2=M 3=W
//   fwd_E_rs, fwd_E_rt          0=pipeline reg 2=M 3=W
//   fwd_M_rt                    0=pipeline reg 3=W
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TNEW_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] D_rs,
  input  logic [REG_ADDR_W-1:0] D_rt,
  input  logic [REG_ADDR_W-1:0] D_A3,
  input  logic                  D_RegWrite,
  input  logic                  Tuse_rs0,
  input  logic                  Tuse_rs1,
  input  logic                  Tuse_rt0,
  input  logic                  Tuse_rt1,
  input  logic                  Tuse_rt2,
  input  logic [TNEW_W-1:0]     D_Tnew,
  output logic                  stall,
  output logic [1:0]            fwd_D_rs,
  output logic [1:0]            fwd_D_rt,
  output logic [1:0]            fwd_E_rs,
  output logic [1:0]            fwd_E_rt,
  output logic [1:0]            fwd_M_rt
);

  logic [REG_ADDR_W-1:0] r_E_A3, r_E_rs, r_E_rt;
  logic [TNEW_W-1:0]     r_E_Tnew;
  logic [REG_ADDR_W-1:0] r_M_A3, r_M_rt;
  logic [TNEW_W-1:0]     r_M_Tnew;
  logic [REG_ADDR_W-1:0] r_W_A3;

  logic [REG_ADDR_W-1:0] w_D_A3_eff;
  logic                  w_rs_used, w_rt_used;
  logic [TNEW_W-1:0]     w_rs_tuse, w_rt_tuse;
  logic                  w_stall;

  // A producer in stage X blocks consumer s if it will still not have its
  // result by the time s is needed.
  function automatic logic hazard(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] s,
    input logic [TNEW_W-1:0]     tuse,
    input logic [REG_ADDR_W-1:0] e_a3,
    input logic [TNEW_W-1:0]     e_tnew,
    input logic [REG_ADDR_W-1:0] m_a3,
    input logic [TNEW_W-1:0]     m_tnew
  );
    hazard = used && (s != '0) &&
             (((e_a3 == s) && (e_tnew > tuse)) ||
              ((m_a3 == s) && (m_tnew > tuse)));
  endfunction

  // Nearest matching stage wins; if it is not ready yet the select stays 0
  // rather than falling through to an older, stale producer.
  function automatic logic [1:0] fwd_sel_d(
    input logic [REG_ADDR_W-1:0] s,
    input logic [REG_ADDR_W-1:0] e_a3,
    input logic [TNEW_W-1:0]     e_tnew,
    input logic [REG_ADDR_W-1:0] m_a3,
    input logic [TNEW_W-1:0]     m_tnew,
    input logic [REG_ADDR_W-1:0] w_a3
  );
    fwd_sel_d = 2'd0;
    if (s != '0) begin
      if (e_a3 == s)      fwd_sel_d = (e_tnew == '0) ? 2'd1 : 2'd0;
      else if (m_a3 == s) fwd_sel_d = (m_tnew == '0) ? 2'd2 : 2'd0;
      else if (w_a3 == s) fwd_sel_d = 2'd3;
    end
  endfunction

  function automatic logic [1:0] fwd_sel_e(
    input logic [REG_ADDR_W-1:0] s,
    input logic [REG_ADDR_W-1:0] m_a3,
    input logic [TNEW_W-1:0]     m_tnew,
    input logic [REG_ADDR_W-1:0] w_a3
  );
    fwd_sel_e = 2'd0;
    if (s != '0) begin
      if (m_a3 == s)      fwd_sel_e = (m_tnew == '0) ? 2'd2 : 2'd0;
      else if (w_a3 == s) fwd_sel_e = 2'd3;
    end
  endfunction

  assign w_D_A3_eff = (D_RegWrite && (D_A3 != '0)) ? D_A3 : '0;

  always_comb begin
    w_rs_used = 1'b1;
    w_rs_tuse = '0;
    if (Tuse_rs0)      w_rs_tuse = TNEW_W'(0);
    else if (Tuse_rs1) w_rs_tuse = TNEW_W'(1);
    else               w_rs_used = 1'b0;

    w_rt_used = 1'b1;
    w_rt_tuse = '0;
    if (Tuse_rt0)      w_rt_tuse = TNEW_W'(0);
    else if (Tuse_rt1) w_rt_tuse = TNEW_W'(1);
    else if (Tuse_rt2) w_rt_tuse = TNEW_W'(2);
    else               w_rt_used = 1'b0;
  end

  always_comb begin
    w_stall = hazard(w_rs_used, D_rs, w_rs_tuse, r_E_A3, r_E_Tnew, r_M_A3, r_M_Tnew) ||
              hazard(w_rt_used, D_rt, w_rt_tuse, r_E_A3, r_E_Tnew, r_M_A3, r_M_Tnew);
  end

  assign stall    = w_stall;
  assign fwd_D_rs = fwd_sel_d(D_rs, r_E_A3, r_E_Tnew, r_M_A3, r_M_Tnew, r_W_A3);
  assign fwd_D_rt = fwd_sel_d(D_rt, r_E_A3, r_E_Tnew, r_M_A3, r_M_Tnew, r_W_A3);
  assign fwd_E_rs = fwd_sel_e(r_E_rs, r_M_A3, r_M_Tnew, r_W_A3);
  assign fwd_E_rt = fwd_sel_e(r_E_rt, r_M_A3, r_M_Tnew, r_W_A3);
  assign fwd_M_rt = ((r_M_rt != '0) && (r_W_A3 == r_M_rt)) ? 2'd3 : 2'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_E_A3   <= '0;
      r_E_Tnew <= '0;
      r_E_rs   <= '0;
      r_E_rt   <= '0;
      r_M_A3   <= '0;
      r_M_Tnew <= '0;
      r_M_rt   <= '0;
      r_W_A3   <= '0;
    end else begin
      if (w_stall) begin
        r_E_A3   <= '0;
        r_E_Tnew <= '0;
        r_E_rs   <= '0;
        r_E_rt   <= '0;
      end else begin
        r_E_A3   <= w_D_A3_eff;
        r_E_Tnew <= D_Tnew;
        r_E_rs   <= D_rs;
        r_E_rt   <= D_rt;
      end
      r_M_A3   <= r_E_A3;
      r_M_Tnew <= (r_E_Tnew == '0) ? '0 : r_E_Tnew - TNEW_W'(1);
      r_M_rt   <= r_E_rt;
      r_W_A3   <= r_M_A3;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_A3;
  logic       D_RegWrite;
  logic       Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2;
  logic [2:0] D_Tnew;
  logic       stall;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;

  int n_vec  = 0;
  int n_fail = 0;

  hazard_ctrl #(.REG_ADDR_W(5), .TNEW_W(3)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_A3(D_A3), .D_RegWrite(D_RegWrite),
    .Tuse_rs0(Tuse_rs0), .Tuse_rs1(Tuse_rs1),
    .Tuse_rt0(Tuse_rt0), .Tuse_rt1(Tuse_rt1), .Tuse_rt2(Tuse_rt2),
    .D_Tnew(D_Tnew), .stall(stall),
    .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
    .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // rs, rt, A3, RegWrite, {rs0,rs1}, {rt0,rt1,rt2}, Tnew
  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                       input logic we, input logic [1:0] trs, input logic [2:0] trt,
                       input logic [2:0] tnew);
    D_rs = rs; D_rt = rt; D_A3 = a3; D_RegWrite = we;
    {Tuse_rs0, Tuse_rs1} = trs;
    {Tuse_rt0, Tuse_rt1, Tuse_rt2} = trt;
    D_Tnew = tnew;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 3'b000, 3'd0);
  endtask

  // Advance one clock; inputs change #1 after the edge, checks run #2 after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    set_d(5'd1, 5'd1, 5'd2, 1'b1, 2'b10, 3'b100, 3'd2);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_stall", {1'b0, stall}, 2'd0);
    chk("reset_fwd_D_rs", fwd_D_rs, 2'd0);
    chk("reset_fwd_D_rt", fwd_D_rt, 2'd0);
    chk("reset_fwd_E_rs", fwd_E_rs, 2'd0);
    chk("reset_fwd_E_rt", fwd_E_rt, 2'd0);
    chk("reset_fwd_M_rt", fwd_M_rt, 2'd0);
    flush();

    // lw $1,0($0) ; addu $2,$1,$3
    set_d(5'd0, 5'd1, 5'd1, 1'b1, 2'b01, 3'b000, 3'd2);
    tick();
    set_d(5'd1, 5'd3, 5'd2, 1'b1, 2'b01, 3'b010, 3'd1);
    #1;
    chk("lwuse_stall1", {1'b0, stall}, 2'd1);
    chk("lwuse_fwdDrs_blocked", fwd_D_rs, 2'd0);
    tick(); #1;
    chk("lwuse_stall2", {1'b0, stall}, 2'd0);
    chk("lwuse_fwdDrs_Mnotready", fwd_D_rs, 2'd0);
    tick();
    nop(); #1;
    chk("lwuse_fwdErs_W", fwd_E_rs, 2'd3);
    chk("lwuse_fwdErt", fwd_E_rt, 2'd0);
    flush();

    // addu $1,$2,$3 ; beq $1,$1
    set_d(5'd2, 5'd3, 5'd1, 1'b1, 2'b01, 3'b010, 3'd1);
    tick();
    set_d(5'd1, 5'd1, 5'd0, 1'b0, 2'b10, 3'b100, 3'd0);
    #1;
    chk("beq_stall1", {1'b0, stall}, 2'd1);
    chk("beq_fwdDrs_blocked", fwd_D_rs, 2'd0);
    tick(); #1;
    chk("beq_stall2", {1'b0, stall}, 2'd0);
    chk("beq_fwdDrs_M", fwd_D_rs, 2'd2);
    chk("beq_fwdDrt_M", fwd_D_rt, 2'd2);
    tick();
    nop(); #1;
    chk("beq_fwdErs_W", fwd_E_rs, 2'd3);
    chk("beq_fwdErt_W", fwd_E_rt, 2'd3);
    flush();

    // jal ; jr $31 ; jr $31
    set_d(5'd0, 5'd0, 5'd31, 1'b1, 2'b00, 3'b000, 3'd0);
    tick();
    set_d(5'd31, 5'd0, 5'd0, 1'b0, 2'b10, 3'b000, 3'd0);
    #1;
    chk("jr_stall", {1'b0, stall}, 2'd0);
    chk("jr_fwdDrs_E", fwd_D_rs, 2'd1);
    tick(); #1;
    // jal now in M; its Tnew of 0 must stay 0 there
    chk("jr2_stall", {1'b0, stall}, 2'd0);
    chk("jr2_fwdDrs_M", fwd_D_rs, 2'd2);
    flush();

    // ori $5,$0,imm ; sw $5,0($0)
    set_d(5'd0, 5'd5, 5'd5, 1'b1, 2'b01, 3'b000, 3'd1);
    tick();
    set_d(5'd0, 5'd5, 5'd0, 1'b0, 2'b01, 3'b001, 3'd0);
    #1;
    chk("sw_stall", {1'b0, stall}, 2'd0);
    chk("sw_fwdDrt_Enotready", fwd_D_rt, 2'd0);
    tick();
    nop(); #1;
    chk("sw_fwdErt_M", fwd_E_rt, 2'd2);
    chk("sw_fwdErs_zero", fwd_E_rs, 2'd0);
    tick(); #1;
    chk("sw_fwdMrt_W", fwd_M_rt, 2'd3);
    flush();

    // lw $0 ; addu $2,$0,$0
    set_d(5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 3'b000, 3'd2);
    tick();
    set_d(5'd0, 5'd0, 5'd2, 1'b1, 2'b01, 3'b010, 3'd1);
    #1;
    chk("r0_stall", {1'b0, stall}, 2'd0);
    chk("r0_fwdDrs", fwd_D_rs, 2'd0);
    chk("r0_fwdDrt", fwd_D_rt, 2'd0);
    flush();

    // lw $4 with RegWrite=0 ; addu $2,$4,$4
    set_d(5'd0, 5'd4, 5'd4, 1'b0, 2'b01, 3'b000, 3'd2);
    tick();
    set_d(5'd4, 5'd4, 5'd2, 1'b1, 2'b01, 3'b010, 3'd1);
    #1;
    chk("nowr_stall", {1'b0, stall}, 2'd0);
    chk("nowr_fwdDrs", fwd_D_rs, 2'd0);
    flush();

    // reset during a stall, then a fresh lw/addu pair
    set_d(5'd0, 5'd1, 5'd1, 1'b1, 2'b01, 3'b000, 3'd2);
    tick();
    set_d(5'd1, 5'd3, 5'd2, 1'b1, 2'b01, 3'b010, 3'd1);
    #1;
    chk("rst_pre_stall", {1'b0, stall}, 2'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_post_stall", {1'b0, stall}, 2'd0);
    chk("rst_post_fwdDrs", fwd_D_rs, 2'd0);
    chk("rst_post_fwdErs", fwd_E_rs, 2'd0);
    chk("rst_post_fwdErt", fwd_E_rt, 2'd0);
    chk("rst_post_fwdMrt", fwd_M_rt, 2'd0);
    set_d(5'd0, 5'd1, 5'd1, 1'b1, 2'b01, 3'b000, 3'd2);
    tick();
    set_d(5'd1, 5'd3, 5'd2, 1'b1, 2'b01, 3'b010, 3'd1);
    #1;
    chk("fresh_stall1", {1'b0, stall}, 2'd1);
    tick(); #1;
    chk("fresh_stall2", {1'b0, stall}, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
